// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with two-flop synchroniser,
// mid-bit sampling, one-cycle strobes and framing-error detect.
module uart_rx #(
  parameter int BAUDRATE = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       ferr,
  output logic       busy
);

  localparam int CW = $clog2(BAUDRATE);
  localparam logic [CW-1:0] FULL = CW'(BAUDRATE - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUDRATE / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          tick;

  assign tick = (cnt == '0);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      data  <= '0;
      rcv   <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      rcv  <= 1'b0;
      ferr <= 1'b0;
      if (!tick) cnt <= cnt - 1'b1;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= HALF;
          end
        end
        START: begin
          if (tick) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              cnt   <= FULL;
              idx   <= '0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= {rx_s, shreg[7:1]};
            idx   <= idx + 3'd1;
            cnt   <= FULL;
            if (idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s) begin
              data  <= shreg;
              rcv   <= 1'b1;
              state <= IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          // hold off start detection until the line recovers
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven, hand-written and randomized checks
// of uart_rx at BAUDRATE=104 and BAUDRATE=5.
module tb_uart_rx;

  localparam int B0 = 104;
  localparam int B1 = 5;

  logic clk = 1'b0;
  logic rst;
  logic rx0, rx5;
  logic [7:0] data0, data5;
  logic rcv0, rcv5, ferr0, ferr5, busy0, busy5;

  always #5 clk = ~clk;

  uart_rx #(.BAUDRATE(B0)) u_rx (
    .clk(clk), .rst(rst), .rx(rx0),
    .data(data0), .rcv(rcv0), .ferr(ferr0), .busy(busy0)
  );

  uart_rx #(.BAUDRATE(B1)) u_rx5 (
    .clk(clk), .rst(rst), .rx(rx5),
    .data(data5), .rcv(rcv5), .ferr(ferr5), .busy(busy5)
  );

  int total = 0;
  int bad = 0;

  // monitor-owned state
  logic [7:0] got0[$];
  logic [7:0] got1[$];
  int rcv_n[2];
  int ferr_n[2];
  int busy_run[2];
  int busy_len[2];
  int ovl_n;
  logic [1:0] rcv_prev;

  initial begin
    rcv_n = '{0, 0};
    ferr_n = '{0, 0};
    busy_run = '{0, 0};
    busy_len = '{0, 0};
    ovl_n = 0;
    rcv_prev = 2'b00;
  end

  always @(negedge clk) begin
    logic [1:0] r, f, b;
    r = {rcv5, rcv0};
    f = {ferr5, ferr0};
    b = {busy5, busy0};
    if (rcv0) got0.push_back(data0);
    if (rcv5) got1.push_back(data5);
    for (int k = 0; k < 2; k++) begin
      if (r[k]) rcv_n[k]++;
      if (f[k]) ferr_n[k]++;
      if ((r[k] && f[k]) || (r[k] && rcv_prev[k]) ||
          (f[k] && rcv_prev[k])) ovl_n++;
      if (b[k]) busy_run[k]++;
      else if (busy_run[k] > 0) begin
        busy_len[k] = busy_run[k];
        busy_run[k] = 0;
      end
    end
    rcv_prev = r;
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx5 = v;
    else rx0 = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b,
                            input bit stop_ok, input int hold);
    int br;
    br = sel ? B1 : B0;
    drive(sel, 1'b0);
    repeat (br) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      repeat (br) @(negedge clk);
    end
    if (stop_ok) begin
      drive(sel, 1'b1);
      repeat (br) @(negedge clk);
    end else begin
      drive(sel, 1'b0);
      repeat (hold * br) @(negedge clk);
      drive(sel, 1'b1);
      repeat (br) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    bit         stop_ok;
    int         hold;
    bit         exp_rcv;
    bit         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[8];

  task automatic run_random(input bit sel, input int n);
    logic [7:0] exp_q[$];
    logic [7:0] last;
    int fe, base_r, base_f, rd;
    bit ok;
    logic [7:0] b;
    last = sel ? data5 : data0;
    fe = 0;
    base_r = rcv_n[sel];
    base_f = ferr_n[sel];
    rd = sel ? got1.size() : got0.size();
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(sel, b, ok, $urandom_range(1, 3));
      if (ok) begin
        exp_q.push_back(b);
        last = b;
      end else fe++;
      repeat ($urandom_range(0, 2) * (sel ? B1 : B0)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("rand_rcv_count", rcv_n[sel] - base_r, exp_q.size());
    check("rand_ferr_count", ferr_n[sel] - base_f, fe);
    check("rand_data_last", sel ? data5 : data0, last);
    for (int i = 0; i < exp_q.size(); i++)
      check("rand_byte", sel ? got1[rd+i] : got0[rd+i], exp_q[i]);
  endtask

  initial begin
    logic [7:0] hello[8];
    int r0, f0, rd;

    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h2E, 8'h2E};
    tbl[0] = '{8'h48, 1, 1, 1, 0, 8'h48};
    tbl[1] = '{8'h11, 1, 1, 1, 0, 8'h11};
    tbl[2] = '{8'h55, 0, 3, 0, 1, 8'h11};
    tbl[3] = '{8'hC3, 1, 1, 1, 0, 8'hC3};
    tbl[4] = '{8'h00, 1, 1, 1, 0, 8'h00};
    tbl[5] = '{8'hFF, 1, 1, 1, 0, 8'hFF};
    tbl[6] = '{8'h80, 0, 1, 0, 1, 8'hFF};
    tbl[7] = '{8'h01, 1, 1, 1, 0, 8'h01};

    rst = 1'b1;
    rx0 = 1'b1;
    rx5 = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", data0, 8'h00);
    check("reset_rcv", rcv0, 1'b0);
    check("reset_ferr", ferr0, 1'b0);
    check("reset_busy", busy0, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      r0 = rcv_n[0];
      f0 = ferr_n[0];
      rd = got0.size();
      send_frame(0, tbl[i].b, tbl[i].stop_ok, tbl[i].hold);
      repeat (B0) @(negedge clk);
      check("tbl_rcv", rcv_n[0] - r0, 32'(tbl[i].exp_rcv));
      check("tbl_ferr", ferr_n[0] - f0, 32'(tbl[i].exp_ferr));
      check("tbl_data", data0, tbl[i].exp_data);
      check("tbl_busy_idle", busy0, 1'b0);
      if (tbl[i].exp_rcv) begin
        check("tbl_byte", got0[rd], tbl[i].b);
        check("tbl_busy_len", busy_len[0], B0 / 2 + 9 * B0);
      end
    end

    // back-to-back "Hello!.." with no idle bits
    r0 = rcv_n[0];
    f0 = ferr_n[0];
    rd = got0.size();
    for (int i = 0; i < 8; i++) send_frame(0, hello[i], 1, 1);
    repeat (B0) @(negedge clk);
    check("hello_count", rcv_n[0] - r0, 8);
    check("hello_ferr", ferr_n[0] - f0, 0);
    for (int i = 0; i < 8; i++)
      check("hello_byte", got0[rd+i], hello[i]);

    // 30-cycle glitch is rejected in START
    r0 = rcv_n[0];
    f0 = ferr_n[0];
    rx0 = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_hi", busy0, 1'b1);
    repeat (20) @(negedge clk);
    rx0 = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_busy_lo", busy0, 1'b0);
    check("glitch_rcv", rcv_n[0] - r0, 0);
    check("glitch_ferr", ferr_n[0] - f0, 0);
    send_frame(0, 8'h5A, 1, 1);
    repeat (B0) @(negedge clk);
    check("glitch_next", data0, 8'h5A);

    // framing error with line held low: busy until release
    send_frame(0, 8'h11, 1, 1);
    r0 = rcv_n[0];
    f0 = ferr_n[0];
    rx0 = 1'b0;
    repeat (B0) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx0 = i[0];
      repeat (B0) @(negedge clk);
    end
    rx0 = 1'b0;
    repeat (3 * B0) @(negedge clk);
    check("ferr_busy_hold", busy0, 1'b1);
    check("ferr_pulses", ferr_n[0] - f0, 1);
    rx0 = 1'b1;
    repeat (10) @(negedge clk);
    check("ferr_busy_rel", busy0, 1'b0);
    check("ferr_rcv", rcv_n[0] - r0, 0);
    check("ferr_data", data0, 8'h11);
    send_frame(0, 8'hC3, 1, 1);
    repeat (B0) @(negedge clk);
    check("ferr_next", data0, 8'hC3);
    check("ferr_next_rcv", rcv_n[0] - r0, 1);

    // asynchronous reset in the middle of data bit 4
    rx0 = 1'b0;
    repeat (B0) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx0 = 1'b1;
      repeat (B0) @(negedge clk);
    end
    rx0 = 1'b0;
    repeat (B0 / 2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_data", data0, 8'h00);
    check("arst_busy", busy0, 1'b0);
    check("arst_rcv", rcv0, 1'b0);
    rx0 = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    r0 = rcv_n[0];
    send_frame(0, 8'hA5, 1, 1);
    repeat (B0) @(negedge clk);
    check("arst_next", data0, 8'hA5);
    check("arst_next_rcv", rcv_n[0] - r0, 1);

    // BAUDRATE=5: two frames back-to-back
    r0 = rcv_n[1];
    rd = got1.size();
    send_frame(1, 8'hF0, 1, 1);
    send_frame(1, 8'h0F, 1, 1);
    repeat (3 * B1) @(negedge clk);
    check("b5_count", rcv_n[1] - r0, 2);
    check("b5_first", got1[rd], 8'hF0);
    check("b5_second", got1[rd+1], 8'h0F);
    check("b5_data", data5, 8'h0F);
    check("b5_busy_len", busy_len[1], B1 / 2 + 9 * B1);

    run_random(1, 150);
    run_random(0, 8);

    check("strobe_overlap", ovl_n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for 8N1 frames; consumes the line driven by the team's UART transmitter.
- Sits between the external RX pin and byte-level consumers such as echo, command parsers and string checkers.
- Synchronises the line, detects the start bit and samples each bit at mid-bit.
- Delivers each byte with a one-cycle strobe and flags framing errors.

Parameters:
- BAUDRATE, 104, clock cycles per bit (104 = 115200 baud at 12 MHz); legal range >= 4.

Ports:
- clk  input  1  System clock.
- rst  input  1  Reset; asynchronous, active-high.
- rx  input  1  Serial data input; idle high; asynchronous to clk.
- data  output  8  Last correctly received byte; held until the next good frame.
- rcv  output  1  One-cycle strobe; data is valid and new.
- ferr  output  1  One-cycle strobe; stop bit was sampled low.
- busy  output  1  High while a frame is being received (state != IDLE).

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE; data=0x00; rcv=0; ferr=0; busy=0.
  - Both synchroniser flops=1; bit counter and baud counter=0.
- Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Baud counter: loaded with L-1, decrements once per cycle. A "tick" is the cycle in which the counter is 0; sampling happens on that cycle's edge.
- IDLE:
  - rx_s=0 → START; load BAUDRATE/2-1 (integer division). busy rises on the same edge.
- START, on tick:
  - rx_s=1 → IDLE (glitch); no strobe.
  - rx_s=0 → DATA; load BAUDRATE-1; bit index=0.
- DATA, on each tick:
  - Shift rx_s into bit 7 of the shift register (shift right; LSB-first on the line).
  - Increment bit index and reload BAUDRATE-1.
  - After the 8th sample → STOP.
- STOP, on tick:
  - rx_s=1 → data<=shift register; rcv=1 for exactly the following cycle; → IDLE.
  - rx_s=0 → ferr=1 for exactly the following cycle; data unchanged; → WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then → IDLE. Covers break conditions and prevents false starts.
- Timing:
  - Stop-bit sample occurs BAUDRATE/2 + 9*BAUDRATE cycles after the start-detect edge.
  - rcv and ferr are registered and are high in the cycle after that sample.
- rcv and ferr are never asserted together.
- There is no back-pressure. A consumer that misses rcv loses the byte; data is overwritten only by the next good frame.
- Back-to-back frames (start bit immediately after stop bit) are received with no gap. Detection is re-armed the cycle after the stop sample, which is mid-stop-bit.
- The line is never sampled in IDLE except for start detection. Noise shorter than BAUDRATE/2 cycles is rejected in START.

Test Plan:
- BAUDRATE=104, send frame 0x48 ('H') → rcv pulses once for 1 cycle; data=0x48; ferr stays 0; busy high for about 9.5 bit times, then 0.
- Send "Hello!.." as 8 back-to-back frames with zero idle bits → exactly 8 rcv pulses, with data = 0x48 0x65 0x6C 0x6C 0x6F 0x21 0x2E 0x2E in order; no ferr.
- Drive rx low for 30 cycles then high (BAUDRATE=104) → no rcv, no ferr; busy returns to 0 after the START tick; a following 0x5A frame gives data=0x5A.
- Receive 0x11 good, then send 0x55 with stop bit low and hold rx low for 3 bit times → one ferr pulse, no rcv, data stays 0x11; busy stays high until rx goes high; the next 0xC3 frame gives data=0xC3 with rcv.
- Assert rst during data bit 4 of a frame → data=0x00, busy=0, rcv=0 immediately without waiting for a clk edge; release rst on an idle line; the next 0xA5 frame is received correctly.
- BAUDRATE=5 (odd, minimum-scale), send 0xF0 then 0x0F → data=0xF0 then 0x0F, one rcv each; start sample taken 2 cycles after start detect.
